snail_seq_gen_010: RTL and testbench
====================================

SNAIL_SEQ_GEN_010 -- requirements
Module: snail_seq_gen_010

Interface
REQ-001 Parameter WIDTH, 8, word length in bits (2..32).
REQ-002 Parameter GAP, 2, number of forced-0 cycles after each frame (0..15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word to send.
REQ-007 din_ready  output  1  block accepts a word this cycle.
REQ-008 dout  output  1  serial bit stream, MSB first, one bit per clk; drives the D input of the "010" detector.
REQ-009 busy  output  1  frame or gap in progress.
REQ-010 frame_done  output  1  one-cycle pulse at end of frame.
REQ-011 exp_q  output  1  expected detector output: high in the cycle dout carries the final 0 of a "010".
REQ-012 hit_cnt  output  8  number of exp_q pulses since reset, saturating.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, GAP; all outputs SHALL be registered.
REQ-014 IDLE: din_ready=1, busy=0, dout=0.
REQ-015 Transfer SHALL occur on posedge when din_valid=1 and din_ready=1; din SHALL be captured into a shift register and the FSM SHALL enter SHIFT.
REQ-016 SHIFT: in the cycle after transfer dout=din[WIDTH-1], then din[WIDTH-2] ... din[0] on consecutive cycles, WIDTH cycles total; busy=1, din_ready=0.
REQ-017 After bit din[0], the FSM SHALL enter GAP for GAP cycles with dout=0, busy=1, din_ready=0; GAP=0 SHALL skip GAP directly to IDLE.
REQ-018 On return to IDLE, frame_done SHALL be 1 for exactly that first IDLE cycle; din_ready=1 in the same cycle.
REQ-019 din_valid while din_ready=0 SHALL be ignored; din SHALL not be sampled then.
REQ-020 Frame latency: transfer edge to frame_done = WIDTH+GAP+1 cycles; minimum period between transfers = WIDTH+GAP+1 cycles.
REQ-021 A 2-bit history of the two previous dout values SHALL be updated every cycle, including IDLE and GAP cycles.
REQ-022 exp_q SHALL be 1 when history = (0 older, 1 newer) and current dout=0; overlapping matches count (Mealy "010").
REQ-023 Matches SHALL span frame boundaries, gap bits and idle bits.
REQ-024 hit_cnt SHALL increment by 1 on each exp_q=1 cycle and hold at 255.

Reset
REQ-025 With rst=1 at a posedge, next cycle: state IDLE, dout=0, busy=0, din_ready=1, frame_done=0, exp_q=0, history=00, hit_cnt=0.
REQ-026 rst SHALL override everything, including a transfer in the same cycle and a frame in progress; the aborted frame SHALL produce no frame_done.

Verification
REQ-027 din=8'hA5, GAP=2, one transfer -> dout 1,0,1,0,0,1,0,1,0,0; exp_q high on bits 2,4,7 and gap cycle 1; hit_cnt=4; frame_done at cycle 11 after transfer.
REQ-028 din=8'h00 then 8'hFF back-to-back (valid held) -> second transfer only when din_ready=1; exp_q never high; hit_cnt=0.
REQ-029 din=8'h55 for 64 frames -> 4 hits per frame; hit_cnt reaches 255 and stays 255.
REQ-030 rst=1 during SHIFT bit 4 of 8'hA5 -> next cycle dout=0, busy=0, din_ready=1, hit_cnt=0, no frame_done.
REQ-031 din_valid toggled while busy with different din -> transmitted stream equals only the captured word.
REQ-032 Loopback: dout into the Mealy "010" detector with shared clk -> detector Q equals exp_q every cycle for 1000 cycles of random words.

Source files
------------

// File: rtl/snail_seq_gen_010.sv
// Serializer that emits a word MSB first, follows it with GAP forced-0 cycles and
// predicts, cycle by cycle, the output of a Mealy "010" detector watching dout.
module snail_seq_gen_010 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             busy,
   output logic             frame_done,
   output logic             exp_q,
   output logic [7:0]       hit_cnt
);

   localparam int unsigned CW = 6;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dout_q, dout_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             exp_q_q, exp_d;
   logic [1:0]       hist_q, hist_d;
   logic [7:0]       hit_q, hit_d;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      dout_d  = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;

      unique case (state_q)
         S_SHIFT: begin
            if (cnt_q != '0) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               dout_d  = shreg_q[WIDTH-2];
               cnt_d   = cnt_q - 1'b1;
            end else if (GAP == 0) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_GAP;
               cnt_d   = CW'(GAP - 1);
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            // The word on din is only sampled here, so valid while busy is ignored.
            if (din_valid) begin
               state_d = S_SHIFT;
               shreg_d = din;
               dout_d  = din[WIDTH-1];
               cnt_d   = CW'(WIDTH - 1);
            end else begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
      endcase

      // History seen by the next cycle is {previous dout, current dout}.
      hist_d = {hist_q[0], dout_q};
      exp_d  = (hist_d == 2'b01) && !dout_d;
      hit_d  = (exp_d && hit_q != 8'hFF) ? hit_q + 8'd1 : hit_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         exp_q_q <= 1'b0;
         hist_q  <= 2'b00;
         hit_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         exp_q_q <= exp_d;
         hist_q  <= hist_d;
         hit_q   <= hit_d;
      end
   end

   // NOTE: the shift register is not reset; it is always loaded by a transfer
   // before any of its bits reach dout.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign din_ready  = ready_q;
   assign dout       = dout_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign exp_q      = exp_q_q;
   assign hit_cnt    = hit_q;

endmodule

// File: tb/tb_snail_seq_gen_010.sv
// Bench for snail_seq_gen_010: per-cycle comparison against a frame-indexed model
// and a loopback "010" detector, plus directed scenarios with literal expectations.
module tb_snail_seq_gen_010;

   localparam int W = 8;
   localparam int G = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         dout;
   logic         busy;
   logic         frame_done;
   logic         exp_q;
   logic [7:0]   hit_cnt;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   snail_seq_gen_010 #(.WIDTH(W), .GAP(G)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .busy       (busy),
      .frame_done (frame_done),
      .exp_q      (exp_q),
      .hit_cnt    (hit_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: position k inside the frame decides every output directly.
   bit         m_on = 1'b0;
   bit         m_active;
   int         m_k;
   bit [W-1:0] m_word;
   bit         m_dout, m_prev, m_busy, m_ready, m_fd, m_exp;
   int         m_hit;

   always @(posedge clk) begin
      bit nd, nb, nr, nf;
      if (rst) begin
         m_on = 1'b1; m_active = 1'b0; m_k = 0;
         m_dout = 1'b0; m_prev = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
         m_fd = 1'b0; m_exp = 1'b0; m_hit = 0;
      end else if (m_on) begin
         if (!m_active && din_valid) begin
            m_active = 1'b1; m_word = din; m_k = 1;
         end else if (m_active) begin
            m_k++;
         end
         nd = 1'b0; nb = 1'b0; nr = 1'b1; nf = 1'b0;
         if (m_active) begin
            if (m_k <= W) begin
               nd = m_word[W-m_k]; nb = 1'b1; nr = 1'b0;
            end else if (m_k <= W + G) begin
               nb = 1'b1; nr = 1'b0;
            end else begin
               m_active = 1'b0; nf = 1'b1;
            end
         end
         m_exp  = !m_prev && m_dout && !nd;
         m_prev = m_dout;
         m_dout = nd; m_busy = nb; m_ready = nr; m_fd = nf;
         if (m_exp && m_hit < 255) m_hit++;
      end
   end

   // Loopback Mealy "010" detector; reset leaves it as if a 0 was just seen.
   localparam int D_NONE = 0, D_0 = 1, D_01 = 2;
   int  det_s;
   logic det_q;
   always @(posedge clk) begin
      if (rst) det_s <= D_0;
      else if (dout) det_s <= (det_s == D_0) ? D_01 : D_NONE;
      else det_s <= D_0;
   end
   assign det_q = (det_s == D_01) && !dout;

   always @(negedge clk) begin
      if (m_on) begin
         check("dout",       32'(dout),       32'(m_dout));
         check("busy",       32'(busy),       32'(m_busy));
         check("din_ready",  32'(din_ready),  32'(m_ready));
         check("frame_done", 32'(frame_done), 32'(m_fd));
         check("exp_q",      32'(exp_q),      32'(m_exp));
         check("hit_cnt",    32'(hit_cnt),    32'(m_hit));
         check("detector_q", 32'(det_q),      32'(exp_q));
      end
   end

   initial begin
      logic [9:0] rec_dout, rec_exp;
      int fd_at, fd_cnt;

      rst = 1'b1; din = '0; din_valid = 1'b0;
      step(2);
      check("reset_dout",  32'(dout), 32'd0);
      check("reset_ready", 32'(din_ready), 32'd1);
      check("reset_hit",   32'(hit_cnt), 32'd0);
      rst = 1'b0;

      // Single A5 frame with literal stream, hit positions and frame_done time.
      din = 8'hA5; din_valid = 1'b1;
      step(1);
      din_valid = 1'b0; din = 8'h3C;
      rec_dout = '0; rec_exp = '0; fd_at = 0; fd_cnt = 0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k <= 10) begin
            rec_dout = {rec_dout[8:0], dout};
            rec_exp  = {rec_exp[8:0], exp_q};
         end
         if (frame_done) begin fd_at = k; fd_cnt++; end
      end
      check("a5_stream",   32'(rec_dout), 32'(10'b1010010100));
      check("a5_exp",      32'(rec_exp),  32'(10'b0101001010));
      check("a5_done_at",  32'(fd_at),    32'd11);
      check("a5_done_cnt", 32'(fd_cnt),   32'd1);
      check("a5_hits",     32'(hit_cnt),  32'd4);

      // Reset during bit 4 of an A5 frame: no frame_done may follow.
      step(3);
      din = 8'hA5; din_valid = 1'b1;
      step(1);
      din_valid = 1'b0;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      check("abort_dout",  32'(dout), 32'd0);
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_ready", 32'(din_ready), 32'd1);
      check("abort_hit",   32'(hit_cnt), 32'd0);
      fd_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (frame_done) fd_cnt++;
      end
      check("abort_no_done", 32'(fd_cnt), 32'd0);

      // 00 then FF with valid held: no pattern ever forms.
      rst = 1'b1; step(1); rst = 1'b0;
      din = 8'h00; din_valid = 1'b1;
      step(1);
      din = 8'hFF;
      step(W + G + 1);
      din_valid = 1'b0;
      step(W + G + 3);
      check("zero_ff_hits", 32'(hit_cnt), 32'd0);

      // 64 frames of 55 saturate the hit counter.
      rst = 1'b1; step(1); rst = 1'b0;
      din = 8'h55; din_valid = 1'b1;
      step(63 * (W + G + 1) + 1);
      din_valid = 1'b0;
      step(W + G + 3);
      check("sat_hits", 32'(hit_cnt), 32'd255);
      step(5);
      check("sat_hold", 32'(hit_cnt), 32'd255);

      // Random words and valid toggling, including while busy, with rare resets.
      for (int c = 0; c < 1200; c++) begin
         din       = W'($urandom);
         din_valid = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0; din_valid = 1'b0;
      step(W + G + 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
